pdm_capture_ctrl: RTL and testbench



---
 rtl/pdm_capture_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pdm_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pdm_capture_ctrl
// Description : One-shot PDM capture and ASCII dump sequencer. When a start
//               request is accepted it stores DEPTH PDM bits, one on each
//               pdm_tick strobe. It then streams those bits to uart_tx as
//               '0'/'1' characters over a four-phase go/ready handshake. A
//               CR LF pair follows every LINE_LEN data characters, and the
//               output always ends with exactly one CR LF.
// Ports       :
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start        in   capture request (ignored while busy)
//   pdm_tick     in   one-clk strobe qualifying pdm_dat
//   pdm_dat      in   PDM data bit, already synchronous to clk
//   uart_ready   in   uart_tx idle/ready flag
//   uart_go      out  character request to uart_tx
//   uart_char    out  character presented to uart_tx
//   busy         out  high from accepted start to last character done
//   capture_done out  sticky; set when capture completes, cleared on start
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_capture_ctrl #(
  parameter int         DEPTH     = 128,
  parameter int         LINE_LEN  = 64,
  parameter logic [7:0] CHAR_ONE  = 8'h31,
  parameter logic [7:0] CHAR_ZERO = 8'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pdm_tick,
  input  logic       pdm_dat,
  input  logic       uart_ready,
  output logic       uart_go,
  output logic [7:0] uart_char,
  output logic       busy,
  output logic       capture_done
);

  localparam int IW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(LINE_LEN + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IW-1:0] c_last_idx = IW'(DEPTH - 1);
  localparam logic [IW-1:0] c_depth    = IW'(DEPTH);
  localparam logic [CW-1:0] c_line_len = CW'(LINE_LEN);
  localparam logic [7:0]    c_cr       = 8'h0D;
  localparam logic [7:0]    c_lf       = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_LOAD    = 3'd2,
    S_REQ     = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   wr_idx_q;
  logic [IW-1:0]   rd_idx_q;
  logic [CW-1:0]   col_q;
  logic            lf_q;        // CR of the current line break already sent
  logic            uart_go_q;
  logic [7:0]      uart_char_q;
  logic            busy_q;
  logic            capture_done_q;
  logic [DEPTH-1:0] buf_q;

  logic            w_wr_en;
  logic            w_nl_phase;  // current character belongs to a line break

  assign w_wr_en    = (state_q == S_CAPTURE) && pdm_tick;
  assign w_nl_phase = (col_q == c_line_len);

  // Sample storage carries no reset; it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      buf_q[wr_idx_q[AW-1:0]] <= pdm_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      col_q          <= '0;
      lf_q           <= 1'b0;
      uart_go_q      <= 1'b0;
      uart_char_q    <= 8'h00;
      busy_q         <= 1'b0;
      capture_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A tick coincident with the accepted start is not captured,
          // because writes are only enabled in S_CAPTURE.
          if (start) begin
            state_q        <= S_CAPTURE;
            wr_idx_q       <= '0;
            busy_q         <= 1'b1;
            capture_done_q <= 1'b0;
          end
        end

        S_CAPTURE: begin
          if (pdm_tick) begin
            wr_idx_q <= wr_idx_q + 1'b1;
            if (wr_idx_q == c_last_idx) begin
              capture_done_q <= 1'b1;
              rd_idx_q       <= '0;
              col_q          <= '0;
              lf_q           <= 1'b0;
              state_q        <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (w_nl_phase) begin
            uart_char_q <= lf_q ? c_lf : c_cr;
          end else begin
            uart_char_q <= buf_q[rd_idx_q[AW-1:0]] ? CHAR_ONE : CHAR_ZERO;
          end
          state_q <= S_REQ;
        end

        S_REQ: begin
          // go rises only while ready is high and falls once uart_tx
          // signals acceptance by dropping ready.
          if (!uart_go_q) begin
            if (uart_ready) begin
              uart_go_q <= 1'b1;
            end
          end else if (!uart_ready) begin
            uart_go_q <= 1'b0;
            state_q   <= S_ACK;
          end
        end

        S_ACK: begin
          if (uart_ready) begin
            if (!w_nl_phase) begin
              rd_idx_q <= rd_idx_q + 1'b1;
              // After the final data character, force a line break so the
              // output always ends with exactly one CR LF. When the line is
              // already full, this is the same break that would occur anyway.
              if (rd_idx_q == c_last_idx) begin
                col_q <= c_line_len;
              end else begin
                col_q <= col_q + 1'b1;
              end
              state_q <= S_LOAD;
            end else if (!lf_q) begin
              lf_q    <= 1'b1;
              state_q <= S_LOAD;
            end else begin
              lf_q  <= 1'b0;
              col_q <= '0;
              if (rd_idx_q == c_depth) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_LOAD;
              end
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_go      = uart_go_q;
  assign uart_char    = uart_char_q;
  assign busy         = busy_q;
  assign capture_done = capture_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_capture_ctrl
// Description : Directed bench for pdm_capture_ctrl. It uses two instances,
//               DEPTH=8/LINE_LEN=4 and DEPTH=5/LINE_LEN=4, each served by a
//               uart_tx responder with a configurable ready latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_capture_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, tick_a, dat_a, ready_a, go_a, busy_a, done_a;
  logic [7:0] char_a;
  logic       start_b, tick_b, dat_b, ready_b, go_b, busy_b, done_b;
  logic [7:0] char_b;

  logic auto_a;
  logic man_a;
  logic mr_a = 1'b1;
  logic mr_b = 1'b1;
  int   lat_a;
  int   lat_b = 3;

  assign ready_a = auto_a ? mr_a : man_a;
  assign ready_b = mr_b;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];

  pdm_capture_ctrl #(.DEPTH(8), .LINE_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pdm_tick(tick_a),
    .pdm_dat(dat_a), .uart_ready(ready_a), .uart_go(go_a),
    .uart_char(char_a), .busy(busy_a), .capture_done(done_a)
  );

  pdm_capture_ctrl #(.DEPTH(5), .LINE_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pdm_tick(tick_b),
    .pdm_dat(dat_b), .uart_ready(ready_b), .uart_go(go_b),
    .uart_char(char_b), .busy(busy_b), .capture_done(done_b)
  );

  // uart_tx responders: latch the character on go, drop ready a cycle
  // later, then restore it after the programmed latency.
  always begin
    @(negedge clk);
    if (auto_a && go_a && mr_a) begin
      cap_a.push_back(char_a);
      @(negedge clk);
      mr_a = 1'b0;
      repeat (lat_a) @(negedge clk);
      mr_a = 1'b1;
    end
  end

  always begin
    @(negedge clk);
    if (go_b && mr_b) begin
      cap_b.push_back(char_b);
      @(negedge clk);
      mr_b = 1'b0;
      repeat (lat_b) @(negedge clk);
      mr_b = 1'b1;
    end
  end

  // A rising go while ready is low breaks the handshake.
  logic gp_a = 1'b0;
  logic gp_b = 1'b0;
  always @(negedge clk) begin
    if (go_a && !gp_a && !ready_a) viol++;
    if (go_b && !gp_b && !ready_b) viol++;
    gp_a = go_a;
    gp_b = go_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start request with a coincident tick carrying 0 (must not be stored).
  task automatic pulse_start(input bit b);
    @(negedge clk);
    if (b) begin start_b = 1'b1; tick_b = 1'b1; dat_b = 1'b0; end
    else   begin start_a = 1'b1; tick_a = 1'b1; dat_a = 1'b0; end
    @(negedge clk);
    start_a = 1'b0; tick_a = 1'b0; start_b = 1'b0; tick_b = 1'b0;
  endtask

  task automatic tick(input bit b, input logic d);
    @(negedge clk);
    if (b) begin tick_b = 1'b1; dat_b = d; end
    else   begin tick_a = 1'b1; dat_a = d; end
    @(negedge clk);
    tick_a = 1'b0; tick_b = 1'b0;
  endtask

  task automatic wait_idle(input bit b, input int budget, input string tag);
    int n = 0;
    while ((b ? busy_b : busy_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(b ? busy_b : busy_a), 32'd0);
  endtask

  // e holds the expected characters, first character in the top byte.
  task automatic cmp_seq(input bit b, input logic [95:0] e, input int n, input string tag);
    int sz;
    logic [7:0] obs;
    sz = b ? cap_b.size() : cap_a.size();
    chk({tag, "_count"}, 32'(sz), 32'(n));
    for (int i = 0; i < n; i++) begin
      obs = 8'hxx;
      if (i < sz) obs = b ? cap_b[i] : cap_a[i];
      chk($sformatf("%s_char%0d", tag, i), {24'h0, obs}, {24'h0, e[95-8*i -: 8]});
    end
  endtask

  logic [7:0]  pat1 = 8'b1000_1101;   // 1,0,1,1,0,0,0,1 (bit 0 first)
  logic [7:0]  pat2 = 8'b1001_0110;   // 0,1,1,0,1,0,0,1
  logic [7:0]  pat3 = 8'b0101_0011;   // 1,1,0,0,1,0,1,0
  logic [95:0] exp1 = {8'h31, 8'h30, 8'h31, 8'h31, 8'h0D, 8'h0A,
                       8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
  logic [95:0] exp3 = {8'h31, 8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A,
                       8'h31, 8'h30, 8'h31, 8'h30, 8'h0D, 8'h0A};
  logic [95:0] expb = {8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A,
                       8'h31, 8'h0D, 8'h0A, 24'h0};

  initial begin
    logic [7:0] c0;
    bit         bad;
    int         n;

    rst_n = 1'b0;
    start_a = 1'b0; tick_a = 1'b0; dat_a = 1'b0;
    start_b = 1'b0; tick_b = 1'b0; dat_b = 1'b0;
    auto_a = 1'b1; man_a = 1'b1; lat_a = 20;

    // Reset state
    #1;
    chk("rst_go_a",   32'(go_a),   32'd0);
    chk("rst_char_a", 32'(char_a), 32'h00);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_go_b",   32'(go_b),   32'd0);
    chk("rst_char_b", 32'(char_b), 32'h00);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_done_b", 32'(done_b), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic capture and dump, with start pulses during capture and dump
    pulse_start(1'b0);
    chk("a_busy_start", 32'(busy_a), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
      end
      tick(1'b0, pat1[i]);
    end
    chk("a_done_cap", 32'(done_a), 32'd1);
    chk("a_busy_cap", 32'(busy_a), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); start_a = 1'b1; tick_a = 1'b1; dat_a = i[0];
      @(negedge clk); start_a = 1'b0; tick_a = 1'b0;
    end
    wait_idle(1'b0, 2000, "a_idle");
    cmp_seq(1'b0, exp1, 12, "basic");
    chk("a_done_end", 32'(done_a), 32'd1);

    // Line length that does not divide the depth
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    wait_idle(1'b1, 2000, "b_idle");
    cmp_seq(1'b1, expb, 9, "nonmult");
    chk("b_done_end", 32'(done_b), 32'd1);

    // Handshake stall with manual ready
    auto_a = 1'b0; man_a = 1'b0;
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, pat2[i]);
    repeat (2) @(negedge clk);
    c0 = char_a;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (go_a || char_a !== c0) bad = 1'b1;
    end
    chk("stall_quiet", 32'(bad), 32'd0);
    chk("stall_char",  32'(c0),  32'h30);
    man_a = 1'b1;
    n = 0;
    while (!go_a && n < 10) begin @(negedge clk); n++; end
    chk("go_after_ready", 32'(go_a), 32'd1);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!go_a || char_a !== 8'h30) bad = 1'b1;
    end
    chk("go_held", 32'(bad), 32'd0);
    man_a = 1'b0;
    @(negedge clk);
    chk("go_drop", 32'(go_a), 32'd0);
    man_a = 1'b1;
    n = 0;
    while (!go_a && n < 10) begin @(negedge clk); n++; end
    chk("second_char", 32'(char_a), 32'h31);

    // Asynchronous reset mid-dump, observed before any clock edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_go",   32'(go_a),   32'd0);
    chk("mr_busy", 32'(busy_a), 32'd0);
    chk("mr_done", 32'(done_a), 32'd0);
    chk("mr_char", 32'(char_a), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during the third character, then a fresh full run
    auto_a = 1'b1; lat_a = 5;
    cap_a.delete();
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, pat3[i]);
    n = 0;
    while (cap_a.size() < 3 && n < 500) begin @(negedge clk); n++; end
    chk("third_reached", 32'(cap_a.size() >= 3), 32'd1);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap_a.delete();
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, pat3[i]);
    wait_idle(1'b0, 2000, "restart_idle");
    cmp_seq(1'b0, exp3, 12, "restart");

    chk("handshake_viol", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
